// File: rtl/axi_pkg.sv
// Shared AXI definitions: per-channel payload widths for sizing buffers, plus a
// constant-foldable clog2 helper used for parameter arithmetic.
package axi_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  // id + addr + len + size + burst + lock + cache + prot + qos
  localparam int unsigned AW_PAYLOAD_W = AXI_ID_W + AXI_ADDR_W + 8 + 3 + 2 + 1 + 4 + 3 + 4;
  localparam int unsigned AR_PAYLOAD_W = AW_PAYLOAD_W;
  localparam int unsigned W_PAYLOAD_W  = AXI_DATA_W + AXI_STRB_W + 1;
  localparam int unsigned R_PAYLOAD_W  = AXI_ID_W + AXI_DATA_W + 2 + 1;
  localparam int unsigned B_PAYLOAD_W  = AXI_ID_W + 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read. Kept separate so
// a RAM macro with the same port shape can replace it.
module fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO for AXI channel payloads, with
// occupancy, almost-full/empty flags, synchronous flush and a high-water mark.
module axi_sync_fifo
  import axi_pkg::*;
#(
  parameter int unsigned DATA_W   = 101,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned ADDR_W  = clog2(DEPTH),
  localparam int unsigned CNT_W   = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [CNT_W-1:0]  o_hwm
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axi_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("axi_sync_fifo: AF_LEVEL must not exceed DEPTH");
  end

  // Pointers carry one extra wrap bit so all DEPTH entries are usable.
  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t             PTR_ONE = ptr_t'(1);
  localparam logic [CNT_W-1:0] AF_LVL  = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_LVL  = CNT_W'(AE_LEVEL);

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] hwm_q, hwm_d;
  logic [CNT_W-1:0] cnt_next;
  logic             full, empty, push, pop;

  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready/valid come only from registered pointers, never from s_valid/m_ready.
  assign s_ready = !full;
  assign m_valid = !empty;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hwm_d    = hwm_q;
    cnt_next = '0;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      hwm_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      cnt_next = wr_ptr_d - rd_ptr_d;
      if (cnt_next > hwm_q) hwm_d = cnt_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hwm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hwm_q    <= hwm_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push && !i_flush),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (s_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (m_data)
  );

  assign o_count        = wr_ptr_q - rd_ptr_q;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (o_count >= AF_LVL);
  assign o_almost_empty = (o_count <= AE_LVL);
  assign o_hwm          = hwm_q;

endmodule

// File: tb/tb_axi_sync_fifo.sv
// Self-checking bench for axi_sync_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_axi_sync_fifo;

  localparam int DW    = 101;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = 5;

  typedef logic [DW-1:0] word_t;

  logic          clk;
  logic          rst_n;
  logic          i_flush;
  logic          s_valid;
  logic          s_ready;
  word_t         s_data;
  logic          m_valid;
  logic          m_ready;
  word_t         m_data;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic [CW-1:0] o_hwm;

  int checks = 0;
  int errors = 0;

  // Reference model: contents in order, plus the peak occupancy since reset/flush.
  word_t model_q[$];
  int    model_hwm = 0;

  axi_sync_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (i_flush),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .o_count        (o_count),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_hwm          (o_hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t rand_word();
    logic [127:0] wide;
    wide = {$urandom(), $urandom(), $urandom(), $urandom()};
    return wide[DW-1:0];
  endfunction

  // Advance one clock: decide push/pop from the model's own occupancy, then
  // return 1 time unit after the edge with the model updated.
  task automatic clk_cycle();
    bit    do_push, do_pop, do_flush;
    word_t wdata;
    word_t dropped;
    do_flush = i_flush;
    do_push  = s_valid && (model_q.size() < DEPTH);
    do_pop   = m_ready && (model_q.size() > 0);
    wdata    = s_data;
    @(posedge clk);
    if (do_flush) begin
      model_q.delete();
      model_hwm = 0;
    end else begin
      if (do_pop) dropped = model_q.pop_front();
      if (do_push) model_q.push_back(wdata);
      if (model_q.size() > model_hwm) model_hwm = model_q.size();
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    model_q.delete(); model_hwm = 0;
    clk_cycle();
    checks++; if (o_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", o_full); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (o_almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got=%b exp=1", o_almost_empty); end
    checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got=%b exp=0", o_almost_full); end
    checks++; if (o_hwm !== 5'd0) begin errors++; $display("FAIL reset_hwm got=%0d exp=0", o_hwm); end
  endtask

  task automatic test_fill();
    m_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      s_valid = 1'b1; s_data = word_t'(i);
      clk_cycle();
      checks++; if (o_count !== CW'(i)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, o_count, i); end
      checks++; if (o_almost_full !== (i >= AF)) begin errors++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, o_almost_full, i >= AF); end
      checks++; if (o_full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, o_full, i == DEPTH); end
      checks++; if (s_ready !== (i < DEPTH)) begin errors++; $display("FAIL fill_s_ready[%0d] got=%b exp=%b", i, s_ready, i < DEPTH); end
    end
    s_data = word_t'(32'h99);
    clk_cycle();
    s_valid = 1'b0;
    checks++; if (o_count !== 5'd16) begin errors++; $display("FAIL fill_17th_count got=%0d exp=16", o_count); end
    checks++; if (o_hwm !== 5'd16) begin errors++; $display("FAIL fill_hwm got=%0d exp=16", o_hwm); end
    checks++; if (m_data !== word_t'(1)) begin errors++; $display("FAIL fill_head got=%h exp=1", m_data); end
  endtask

  task automatic test_full_pop_push();
    word_t exp;
    s_valid = 1'b1; m_ready = 1'b1; s_data = word_t'(32'h77);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fpp_s_ready_full got=%b exp=0", s_ready); end
    checks++; if (m_data !== word_t'(1)) begin errors++; $display("FAIL fpp_pop_data got=%h exp=1", m_data); end
    clk_cycle();
    checks++; if (o_count !== 5'd15) begin errors++; $display("FAIL fpp_count_after_pop got=%0d exp=15", o_count); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fpp_s_ready_after_pop got=%b exp=1", s_ready); end
    m_ready = 1'b0;
    clk_cycle();
    s_valid = 1'b0;
    checks++; if (o_count !== 5'd16) begin errors++; $display("FAIL fpp_count_refill got=%0d exp=16", o_count); end
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < DEPTH - 1) ? word_t'(i + 2) : word_t'(32'h77);
      checks++; if (m_data !== exp || m_valid !== 1'b1) begin errors++; $display("FAIL fpp_drain[%0d] got=%h valid=%b exp=%h", i, m_data, m_valid, exp); end
      clk_cycle();
    end
    m_ready = 1'b0;
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL fpp_empty_after_drain got=%b exp=1", o_empty); end
  endtask

  task automatic test_stream();
    word_t sent[40];
    i_flush = 1'b1;
    clk_cycle();
    i_flush = 1'b0;
    checks++; if (o_hwm !== 5'd0) begin errors++; $display("FAIL stream_hwm_cleared got=%0d exp=0", o_hwm); end
    s_valid = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      sent[k] = rand_word();
      s_data  = sent[k];
      if (k > 0) begin
        checks++; if (m_data !== sent[k-1] || m_valid !== 1'b1) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", k - 1, m_data, sent[k-1]); end
      end
      clk_cycle();
      checks++; if (o_count !== 5'd1) begin errors++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, o_count); end
    end
    s_valid = 1'b0;
    checks++; if (m_data !== sent[39]) begin errors++; $display("FAIL stream_data[39] got=%h exp=%h", m_data, sent[39]); end
    clk_cycle();
    m_ready = 1'b0;
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL stream_empty got=%b exp=1", o_empty); end
    checks++; if (o_hwm !== 5'd1) begin errors++; $display("FAIL stream_hwm got=%0d exp=1", o_hwm); end
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = word_t'(i + 32'h30);
      clk_cycle();
    end
    s_data = word_t'(32'hAA); i_flush = 1'b1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL flush_s_ready got=%b exp=1", s_ready); end
    clk_cycle();
    i_flush = 1'b0; s_valid = 1'b0;
    checks++; if (o_count !== 5'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", o_count); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", o_empty); end
    checks++; if (o_hwm !== 5'd0) begin errors++; $display("FAIL flush_hwm got=%0d exp=0", o_hwm); end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_no_output[%0d] got m_valid=%b data=%h exp valid=0", i, m_valid, m_data); end
      clk_cycle();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = word_t'(i + 32'h40);
      clk_cycle();
    end
    s_valid = 1'b0;
    checks++; if (o_count !== 5'd3) begin errors++; $display("FAIL areset_pre_count got=%0d exp=3", o_count); end
    #2 rst_n = 1'b0;
    model_q.delete(); model_hwm = 0;
    #1;
    checks++; if (o_count !== 5'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", o_count); end
    checks++; if (o_empty !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL areset_empty got empty=%b m_valid=%b exp 1/0", o_empty, m_valid); end
    checks++; if (s_ready !== 1'b1 || o_hwm !== 5'd0) begin errors++; $display("FAIL areset_ready_hwm got s_ready=%b hwm=%0d exp 1/0", s_ready, o_hwm); end
    #2 rst_n = 1'b1;
    s_valid = 1'b1; s_data = word_t'(32'h55);
    clk_cycle();
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== word_t'(32'h55)) begin errors++; $display("FAIL areset_post_push got valid=%b data=%h exp 1/55", m_valid, m_data); end
  endtask

  task automatic test_random();
    int vp, rp, sz;
    for (int i = 0; i < 400; i++) begin
      vp = (i < 200) ? 85 : 30;
      rp = (i < 200) ? 30 : 85;
      s_valid = ($urandom_range(99) < vp);
      m_ready = ($urandom_range(99) < rp);
      i_flush = ($urandom_range(63) == 0);
      s_data  = rand_word();
      clk_cycle();
      sz = model_q.size();
      checks++;
      if (o_count !== CW'(sz) || o_hwm !== CW'(model_hwm) ||
          o_full !== (sz == DEPTH) || o_empty !== (sz == 0) ||
          s_ready !== (sz < DEPTH) || m_valid !== (sz > 0) ||
          o_almost_full !== (sz >= AF) || o_almost_empty !== (sz <= AE)) begin
        errors++;
        $display("FAIL rand_state[%0d] got cnt=%0d hwm=%0d full=%b empty=%b rdy=%b vld=%b af=%b ae=%b exp cnt=%0d hwm=%0d",
                 i, o_count, o_hwm, o_full, o_empty, s_ready, m_valid, o_almost_full, o_almost_empty, sz, model_hwm);
      end
      if (sz > 0) begin
        checks++; if (m_data !== model_q[0]) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, m_data, model_q[0]); end
      end
    end
    s_valid = 1'b0; m_ready = 1'b0; i_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop_push();
    test_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
